// File: rtl/my_logic_pipe.sv
// Pipelined bitwise logic unit: AND/OR/XOR/NAND of two operands or against a
// running accumulator, with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  producer handshake (in_ready = advance)
//   a, b, op            operands and op select (00 AND, 01 OR, 10 XOR, 11 NAND)
//   acc_en, acc_clr     accumulate a into acc / load acc with a (clr wins)
//   out_valid, out_ready consumer handshake
//   out, out_any, out_all result and its OR/AND reductions (registered)
module my_logic_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_any,
    output logic             out_all
);

    typedef struct packed {
        logic             v;
        logic             any;
        logic             all;
        logic [WIDTH-1:0] d;
    } stage_t;

    stage_t           pipe [STAGES];
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res;
    logic             advance;
    logic             accept;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        r = '0;
        unique case (sel)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x & y);
        endcase
        return r;
    endfunction

    // Whole pipe moves together; a stall freezes bubbles too.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    // acc_clr and acc_en may both be set, so this is a priority select.
    always_comb begin
        res = '0;
        priority case (1'b1)
            acc_clr: res = a;
            acc_en:  res = logic_op(op, acc, a);
            default: res = logic_op(op, a, b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (accept && (acc_clr || acc_en)) begin
                acc <= res;
            end
            if (advance) begin
                if (accept) begin
                    pipe[0] <= '{v: 1'b1, any: |res, all: &res, d: res};
                end else begin
                    pipe[0] <= '0;
                end
                for (int i = 1; i < STAGES; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign out_valid = pipe[STAGES-1].v;
    assign out       = pipe[STAGES-1].d;
    assign out_any   = pipe[STAGES-1].any;
    assign out_all   = pipe[STAGES-1].all;

endmodule

// File: tb/tb_my_logic_pipe.sv
// Testbench for my_logic_pipe: table vectors through a scoreboard, plus
// latency, backpressure, mid-flight reset and STAGES=1/4 sequences.
module tb_my_logic_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] a, b;
    logic [1:0]  op;
    logic        acc_en, acc_clr;
    logic        out_valid, out_ready;
    logic [15:0] out;
    logic        out_any, out_all;

    logic        s_valid, s_rdy1, s_rdy4;
    logic [7:0]  s_a, s_b;
    logic        s_ov1, s_ov4, s_any1, s_any4, s_all1, s_all4;
    logic [7:0]  s_o1, s_o4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] d;
        logic        any;
        logic        all;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        en;
        logic        clr;
        logic [15:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vt[12];

    always #5 clk = ~clk;

    my_logic_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_any(out_any), .out_all(out_all)
    );

    my_logic_pipe #(.WIDTH(8), .STAGES(1)) d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(s_rdy1),
        .a(s_a), .b(s_b), .op(2'b01),
        .acc_en(1'b0), .acc_clr(1'b0),
        .out_valid(s_ov1), .out_ready(1'b1),
        .out(s_o1), .out_any(s_any1), .out_all(s_all1)
    );

    my_logic_pipe #(.WIDTH(8), .STAGES(4)) d4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(s_rdy4),
        .a(s_a), .b(s_b), .op(2'b01),
        .acc_en(1'b0), .acc_clr(1'b0),
        .out_valid(s_ov4), .out_ready(1'b1),
        .out(s_o4), .out_any(s_any4), .out_all(s_all4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard consumer: every handshake on the output pops one entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual=%h required=none", out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_out", {16'h0, out}, {16'h0, e.d});
                chk("sb_any", {31'h0, out_any}, {31'h0, e.any});
                chk("sb_all", {31'h0, out_all}, {31'h0, e.all});
            end
        end
    end

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        op       = v.op;
        acc_en   = v.en;
        acc_clr  = v.clr;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        drive(v);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back('{d: v.exp, any: |v.exp, all: &v.exp});
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_ready required=ready");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb,
                                input logic [1:0] vop, input logic ven,
                                input logic vclr, input logic [15:0] vexp);
        vec_t v;
        v.a   = va;
        v.b   = vb;
        v.op  = vop;
        v.en  = ven;
        v.clr = vclr;
        v.exp = vexp;
        return v;
    endfunction

    initial begin
        vt[0]  = mk(16'h0000, 16'hFFFF, 2'b01, 0, 0, 16'hFFFF);
        vt[1]  = mk(16'hE000, 16'hA000, 2'b01, 0, 0, 16'hE000);
        vt[2]  = mk(16'h000C, 16'hE000, 2'b01, 0, 0, 16'hE00C);
        vt[3]  = mk(16'hFFFF, 16'hFFFF, 2'b11, 0, 0, 16'h0000);
        vt[4]  = mk(16'hF0F0, 16'hFF00, 2'b10, 0, 0, 16'h0FF0);
        vt[5]  = mk(16'hE000, 16'h5555, 2'b00, 0, 1, 16'hE000);
        vt[6]  = mk(16'h000C, 16'hFFFF, 2'b01, 1, 0, 16'hE00C);
        vt[7]  = mk(16'h0300, 16'h0000, 2'b01, 1, 0, 16'hE30C);
        vt[8]  = mk(16'hF00F, 16'h0000, 2'b00, 1, 0, 16'hE00C);
        vt[9]  = mk(16'h1234, 16'h0000, 2'b01, 1, 1, 16'h1234);
        vt[10] = mk(16'h0F0F, 16'h00FF, 2'b00, 0, 0, 16'h000F);
        vt[11] = mk(16'hFFFF, 16'h0000, 2'b11, 1, 0, 16'hEDCB);

        rst_n = 1'b0;
        idle();
        a = '0; b = '0; op = '0;
        out_ready = 1'b1;
        s_valid = 1'b0; s_a = 8'h0F; s_b = 8'h30;
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out", {16'h0, out}, 32'h0);
        chk("rst_any", {31'h0, out_any}, 32'h0);
        chk("rst_all", {31'h0, out_all}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Two-stage latency: not visible after the accept edge, visible one later.
        send(vt[0]);
        idle();
        @(negedge clk);
        chk("lat_early_valid", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("lat_valid", {31'h0, out_valid}, 32'h1);
        chk("lat_out", {16'h0, out}, 32'h0000FFFF);
        @(posedge clk);
        #1;

        for (int i = 1; i < 12; i++) begin
            send(vt[i]);
        end
        idle();
        cycles(4);
        chk("table_drained", sb.size(), 32'h0);

        // Backpressure; acc is EDCB here.
        out_ready = 1'b0;
        send(mk(16'h0001, 16'h0002, 2'b01, 0, 0, 16'h0003));
        send(mk(16'h00FF, 16'h0F0F, 2'b10, 0, 0, 16'h0FF0));
        drive(mk(16'h0001, 16'h0000, 2'b10, 1, 0, 16'hEDCA));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
            chk("bp_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_out", {16'h0, out}, 32'h00000003);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(mk(16'h0001, 16'h0000, 2'b10, 1, 0, 16'hEDCA));
        send(mk(16'h0000, 16'h0000, 2'b01, 1, 0, 16'hEDCA));
        idle();
        cycles(4);
        chk("bp_drained", sb.size(), 32'h0);

        // Reset with two results in flight.
        send(mk(16'hAAAA, 16'h0000, 2'b00, 0, 1, 16'hAAAA));
        send(mk(16'h0001, 16'h0000, 2'b01, 0, 0, 16'h0001));
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_out", {16'h0, out}, 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        send(mk(16'h0001, 16'hFFFF, 2'b01, 1, 0, 16'h0001));
        idle();
        cycles(4);
        chk("rst_drained", sb.size(), 32'h0);

        // STAGES=1 and STAGES=4 instances, WIDTH=8.
        s_valid = 1'b1;
        @(negedge clk);
        chk("s1_ready", {31'h0, s_rdy1}, 32'h1);
        chk("s4_ready", {31'h0, s_rdy4}, 32'h1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("s1_valid", {31'h0, s_ov1}, (c == 1) ? 32'h1 : 32'h0);
            chk("s4_valid", {31'h0, s_ov4}, (c == 4) ? 32'h1 : 32'h0);
            if (c == 1) chk("s1_out", {24'h0, s_o1}, 32'h3F);
            if (c == 4) chk("s4_out", {24'h0, s_o4}, 32'h3F);
            if (c == 4) chk("s4_all", {31'h0, s_all4}, 32'h0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
